tc_filter: RTL
==============

TC_FILTER -- requirements
Module: tc_filter

Interface
REQ-001 SHALL have parameter D_BITS, default 12, meaning the width of input samples and output data.
REQ-002 SHALL have parameter LOG2_WIN, default 3, meaning the averaging window is 2^LOG2_WIN samples (range 1..6).
REQ-003 SHALL have parameter TIMEOUT, default 100000, meaning the number of clk_100 cycles without in_valid before the output is flagged stale.
REQ-004 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk_100  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  D_BITS  time-constant sample from the measurement stage.
- in_valid  input  1  single-cycle strobe qualifying in_data.
- recal  input  1  single-cycle request to re-acquire the baseline.
- out_data  output  D_BITS  baseline-relative, averaged value.
- out_valid  output  1  single-cycle strobe qualifying out_data.
- calibrated  output  1  high while a valid baseline is held.
- stale  output  1  high when no sample has arrived within TIMEOUT cycles.

Function
REQ-005 SHALL implement a state machine with states IDLE, CAL and RUN; reset enters IDLE.
REQ-006 SHALL transition from IDLE to CAL one cycle after reset deasserts, clearing the window buffer, running sum and sample count.
REQ-007 In CAL, SHALL accept 2^LOG2_WIN samples into the window, then set baseline = sum >> LOG2_WIN, assert calibrated and enter RUN on the cycle after the last sample.
REQ-008 SHALL keep out_valid low in IDLE and CAL.
REQ-009 In RUN, on each in_valid SHALL replace the oldest window entry, update the running sum as sum + new - oldest (width D_BITS+LOG2_WIN, no overflow), and compute avg = sum >> LOG2_WIN.
REQ-010 In RUN, SHALL produce out_data = avg - baseline, saturated to 0 when avg < baseline and never wrapping.
REQ-011 SHALL assert out_valid exactly 2 cycles after the accepted in_valid, for exactly one cycle.
REQ-012 SHALL hold out_data between strobes.
REQ-013 On in_valid in two consecutive cycles, SHALL process both samples and produce two out_valid pulses in consecutive cycles.
REQ-014 On recal in any state, SHALL enter CAL on the next cycle, deassert calibrated and clear the window, sum and count. Any in-flight result SHALL be discarded (no out_valid).
REQ-015 If recal and in_valid occur in the same cycle, recal SHALL win and the sample SHALL be dropped.
REQ-016 SHALL run a timeout counter that is cleared on every in_valid, saturates at TIMEOUT, and holds stale high while it equals TIMEOUT.
REQ-017 SHALL deassert stale in the cycle after the next in_valid.
REQ-018 SHALL wrap the window write pointer modulo 2^LOG2_WIN.

Reset
REQ-019 While reset is high, SHALL drive out_data=0, out_valid=0, calibrated=0 and stale=0.
REQ-020 While reset is high, SHALL clear the state to IDLE and zero the sum, baseline, count, pointer and timeout counter.
REQ-021 SHALL clear all window entries on reset and on entry to CAL.
REQ-022 Reset asserted mid-calibration or mid-RUN SHALL discard all partial results.

Configuration
REQ-023 SHALL support the macro TC_FILTER_OUTLIER_EN.
- When defined, in RUN a sample whose absolute difference from the current avg exceeds avg >> 2 SHALL be dropped: no window update and no out_valid. The timeout counter SHALL still be cleared.
- After 4 consecutive drops, the 4th sample SHALL be accepted unconditionally.
REQ-024 Without TC_FILTER_OUTLIER_EN, all samples SHALL be accepted and no outlier logic SHALL be synthesised.

Structure
REQ-025 SHALL take from the shared package tc_pkg:
- the state enum (IDLE, CAL, RUN);
- the default D_BITS;
- the outlier drop limit (4).
REQ-026 SHALL instantiate one sub-module, tc_avg_window, which contains the circular buffer, write pointer and running sum. tc_filter SHALL contain the FSM, baseline, saturation, timeout and outlier logic.

Verification
REQ-027 Calibration: after reset, apply 8 samples of 1000 (LOG2_WIN=3) -> calibrated=1, no out_valid during CAL.
REQ-028 Step response: after REQ-027, apply 8 samples of 1080 -> out_data = 10, 20, ..., 80, each 2 cycles after in_valid.
REQ-029 Saturation and back-to-back: after calibrating at 1000, apply 8 samples of 900 -> out_data = 0 throughout. Then apply in_valid in consecutive cycles -> out_valid in consecutive cycles.
REQ-030 Recal and stale:
- Pulse recal coincident with in_valid mid-RUN -> calibrated=0 next cycle and the sample is dropped.
- Withhold input for TIMEOUT cycles -> stale=1; the next sample -> stale=0.
REQ-031 With TC_FILTER_OUTLIER_EN, at avg 1000: a single sample of 2000 -> no out_valid, avg unchanged; 4 consecutive samples of 2000 -> the 4th is accepted.

Source files
------------

// File: rtl/tc_pkg.sv
// ---------------------------------------------------------------------------
// tc_pkg
// Shared definitions for the time-constant filter slice.
//   tc_state_e        : controller states (IDLE, CAL, RUN)
//   TC_D_BITS         : default sample / output width
//   TC_OUTLIER_LIMIT  : number of consecutive outliers after which the
//                       last one is taken anyway (only used when
//                       TC_FILTER_OUTLIER_EN is defined)
// ---------------------------------------------------------------------------
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        RUN  = 2'd2
    } tc_state_e;

    localparam int TC_D_BITS        = 12;
    localparam int TC_OUTLIER_LIMIT = 4;

endpackage : tc_pkg

// File: rtl/tc_avg_window.sv
// ---------------------------------------------------------------------------
// tc_avg_window
// Circular buffer of 2^LOG2_WIN samples with a running sum.
// Every write replaces the oldest entry and updates the sum as
// sum + new - oldest, so the sum always equals the total of the buffer.
//
// Ports
//   clk_100   : clock
//   reset     : synchronous active-high reset (clears buffer, pointer, sum)
//   clear     : synchronous clear, same effect as reset
//   wr_en     : write wr_data into the slot at the write pointer
//   wr_data   : sample to write
//   sum       : registered running sum of the buffer
//   sum_next  : value sum takes after this cycle's write (used by the
//               controller to capture the baseline on the last CAL sample)
// ---------------------------------------------------------------------------
module tc_avg_window import tc_pkg::*; #(
    parameter int D_BITS   = TC_D_BITS,
    parameter int LOG2_WIN = 3
) (
    input  logic                         clk_100,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [D_BITS-1:0]            wr_data,
    output logic [D_BITS+LOG2_WIN-1:0]   sum,
    output logic [D_BITS+LOG2_WIN-1:0]   sum_next
);

    localparam int WIN    = 1 << LOG2_WIN;
    localparam int S_BITS = D_BITS + LOG2_WIN;

    logic [D_BITS-1:0]   win_reg [WIN];
    logic [LOG2_WIN-1:0] ptr_reg;
    logic [S_BITS-1:0]   sum_reg;
    logic [D_BITS-1:0]   oldest;

    // The slot about to be overwritten holds the oldest sample.
    assign oldest = win_reg[ptr_reg];

    // The oldest value is always part of sum_reg, so the result never
    // underflows; S_BITS is wide enough for WIN full-scale samples.
    assign sum_next = wr_en ? (sum_reg + S_BITS'(wr_data) - S_BITS'(oldest))
                            : sum_reg;

    assign sum = sum_reg;

    // The buffer must be cleared in a single cycle, so it lives in flops.
    always_ff @(posedge clk_100) begin
        if (reset || clear) begin
            for (int i = 0; i < WIN; i++) begin
                win_reg[i] <= '0;
            end
        end else if (wr_en) begin
            win_reg[ptr_reg] <= wr_data;
        end
    end

    // Pointer is exactly LOG2_WIN bits wide, so it wraps modulo 2^LOG2_WIN.
    always_ff @(posedge clk_100) begin
        if (reset || clear) begin
            ptr_reg <= '0;
            sum_reg <= '0;
        end else begin
            if (wr_en) begin
                ptr_reg <= ptr_reg + LOG2_WIN'(1);
            end
            sum_reg <= sum_next;
        end
    end

endmodule : tc_avg_window

// File: rtl/tc_filter.sv
// ---------------------------------------------------------------------------
// tc_filter
// Baseline-relative moving-average filter for time-constant samples.
// After reset (or a recal request) the first 2^LOG2_WIN samples are
// averaged into a baseline. Afterwards every accepted sample updates a
// moving average and the block emits max(avg - baseline, 0) two cycles
// after the sample strobe. A timeout counter flags stale input.
//
// Optional feature macro: TC_FILTER_OUTLIER_EN
//   When defined, RUN-state samples deviating from the current average by
//   more than avg/4 are dropped, except that the TC_OUTLIER_LIMIT-th
//   consecutive outlier is accepted. Without it no outlier logic exists.
//
// Ports
//   clk_100    : sole clock
//   reset      : synchronous active-high reset
//   in_data    : sample from the measurement stage
//   in_valid   : single-cycle strobe qualifying in_data
//   recal      : single-cycle request to re-acquire the baseline
//   out_data   : baseline-relative averaged value (held between strobes)
//   out_valid  : single-cycle strobe qualifying out_data
//   calibrated : high while a valid baseline is held
//   stale      : high when no sample arrived within TIMEOUT cycles
// ---------------------------------------------------------------------------
module tc_filter import tc_pkg::*; #(
    parameter int D_BITS   = TC_D_BITS,
    parameter int LOG2_WIN = 3,
    parameter int TIMEOUT  = 100000
) (
    input  logic              clk_100,
    input  logic              reset,
    input  logic [D_BITS-1:0] in_data,
    input  logic              in_valid,
    input  logic              recal,
    output logic [D_BITS-1:0] out_data,
    output logic              out_valid,
    output logic              calibrated,
    output logic              stale
);

    localparam int S_BITS  = D_BITS + LOG2_WIN;
    localparam int WIN     = 1 << LOG2_WIN;
    localparam int TO_BITS = $clog2(TIMEOUT + 1);
    localparam logic [TO_BITS-1:0]  TO_MAX   = TO_BITS'(TIMEOUT);
    localparam logic [LOG2_WIN-1:0] CNT_LAST = LOG2_WIN'(WIN - 1);

    tc_state_e           state_reg;
    logic [LOG2_WIN-1:0] count_reg;
    logic [D_BITS-1:0]   baseline_reg;
    logic [D_BITS-1:0]   out_data_reg;
    logic                out_valid_reg;
    logic                calibrated_reg;
    logic                valid1_reg;
    logic [TO_BITS-1:0]  to_reg;
    logic [TO_BITS-1:0]  to_next;
    logic                stale_reg;

    logic [S_BITS-1:0]   sum;
    logic [S_BITS-1:0]   sum_next;
    logic [D_BITS-1:0]   avg;
    logic [D_BITS-1:0]   avg_next;
    logic [D_BITS-1:0]   rel_value;
    logic                win_clear;
    logic                win_wr;
    logic                sample_ok;
    logic                cal_last;

    // sum >> LOG2_WIN never exceeds full-scale D_BITS, so truncation is safe.
    assign avg      = D_BITS'(sum >> LOG2_WIN);
    assign avg_next = D_BITS'(sum_next >> LOG2_WIN);

    // Saturating subtraction: a negative deviation reads as zero.
    assign rel_value = (avg >= baseline_reg) ? (avg - baseline_reg) : '0;

    // Window is wiped on every entry into CAL: leaving IDLE or on recal.
    assign win_clear = (state_reg == IDLE) || recal;

    // recal beats a coincident sample; IDLE ignores samples.
    assign win_wr = in_valid && !recal &&
                    ((state_reg == CAL) || ((state_reg == RUN) && sample_ok));

    assign cal_last = (state_reg == CAL) && win_wr && (count_reg == CNT_LAST);

    tc_avg_window #(
        .D_BITS   (D_BITS),
        .LOG2_WIN (LOG2_WIN)
    ) u_window (
        .clk_100  (clk_100),
        .reset    (reset),
        .clear    (win_clear),
        .wr_en    (win_wr),
        .wr_data  (in_data),
        .sum      (sum),
        .sum_next (sum_next)
    );

    // -----------------------------------------------------------------------
    // Outlier rejection
    // -----------------------------------------------------------------------
`ifdef TC_FILTER_OUTLIER_EN
    localparam int DROP_BITS = (TC_OUTLIER_LIMIT > 2) ? $clog2(TC_OUTLIER_LIMIT) : 1;
    localparam logic [DROP_BITS-1:0] DROP_LAST = DROP_BITS'(TC_OUTLIER_LIMIT - 1);

    logic [DROP_BITS-1:0] drop_cnt_reg;
    logic [D_BITS-1:0]    deviation;
    logic                 is_outlier;

    // Deviation is judged against the average before this sample lands.
    always_comb begin
        deviation  = (in_data > avg) ? (in_data - avg) : (avg - in_data);
        is_outlier = deviation > (avg >> 2);
        sample_ok  = !is_outlier || (drop_cnt_reg == DROP_LAST);
    end

    // Counts consecutive dropped samples; any accepted sample restarts it.
    always_ff @(posedge clk_100) begin
        if (reset || recal || (state_reg != RUN)) begin
            drop_cnt_reg <= '0;
        end else if (in_valid) begin
            drop_cnt_reg <= sample_ok ? '0 : (drop_cnt_reg + DROP_BITS'(1));
        end
    end
`else
    assign sample_ok = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // Controller FSM and output pipeline
    //   cycle T   : in_valid accepted, window/sum updated at the edge
    //   cycle T+1 : valid1_reg high, avg reflects the new sample
    //   cycle T+2 : out_valid / out_data registered
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            baseline_reg   <= '0;
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            calibrated_reg <= 1'b0;
            valid1_reg     <= 1'b0;
        end else begin
            valid1_reg    <= 1'b0;
            out_valid_reg <= 1'b0;

            if (recal) begin
                // Dropping valid1_reg here discards any in-flight result.
                state_reg      <= CAL;
                count_reg      <= '0;
                calibrated_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg      <= CAL;
                        count_reg      <= '0;
                        calibrated_reg <= 1'b0;
                    end

                    CAL: begin
                        if (win_wr) begin
                            count_reg <= count_reg + LOG2_WIN'(1);
                        end
                        // Baseline taken from the sum including the last sample.
                        if (cal_last) begin
                            baseline_reg   <= avg_next;
                            calibrated_reg <= 1'b1;
                            state_reg      <= RUN;
                        end
                    end

                    RUN: begin
                        valid1_reg <= win_wr;
                        if (valid1_reg) begin
                            out_valid_reg <= 1'b1;
                            out_data_reg  <= rel_value;
                        end
                    end

                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Input timeout: counts idle cycles, saturating at TIMEOUT.
    // stale_reg mirrors (to_reg == TIMEOUT) by registering the next value.
    // -----------------------------------------------------------------------
    always_comb begin
        to_next = to_reg;
        if (in_valid) begin
            to_next = '0;
        end else if (to_reg != TO_MAX) begin
            to_next = to_reg + TO_BITS'(1);
        end
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            to_reg    <= '0;
            stale_reg <= 1'b0;
        end else begin
            to_reg    <= to_next;
            stale_reg <= (to_next == TO_MAX);
        end
    end

    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign calibrated = calibrated_reg;
    assign stale      = stale_reg;

endmodule : tc_filter
